imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time loader/sequencer for the instruction memory. Accepts a byte stream (valid/ready),
//  reads a word-count header, packs bytes little-endian into WIDTH-bit words and issues one
//  write pulse per word to the memory's auto-incrementing write port. Holds the CPU in reset
//  until the load completes cleanly; flags malformed headers.
// PARAMETERS
//  WIDTH  32   instruction word width; must be a multiple of 8 (BPW = WIDTH/8 bytes per word)
//  DEPTH  128  instruction memory depth in words; max legal header value
//  CNT_W  8    width of word_count; must hold DEPTH
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      pulse: begin a load (honoured only in IDLE, DONE, ERR)
//  in_valid    in   1      byte stream valid
//  in_data     in   8      byte stream data
//  in_ready    out  1      loader accepts a byte when in_valid && in_ready
//  mem_clr     out  1      one-cycle pulse to the memory's rst (rewinds its write pointer to 0)
//  mem_write   out  1      one-cycle write strobe to the memory
//  mem_wdata   out  WIDTH  word to write, valid while mem_write=1
//  word_count  out  CNT_W  words written so far in the current load
//  busy        out  1      1 in CLEAR/LEN/LOAD/WRITE
//  done        out  1      1 in DONE
//  error       out  1      1 in ERR
//  cpu_hold    out  1      1 except in DONE; drives the CPU core reset
// BEHAVIOUR
//  All outputs are registered. On rst (any state, mid-load included): state=IDLE; in_ready=0,
//   mem_clr=0, mem_write=0, mem_wdata=0, word_count=0, busy=0, done=0, error=0, cpu_hold=1.
//   Partial word and byte index are discarded.
//  States: IDLE, CLEAR, LEN, LOAD, WRITE, DONE, ERR.
//  IDLE : start -> CLEAR. Otherwise stay.
//  CLEAR: exactly one cycle, mem_clr=1, word_count<=0, byte index<=0, cpu_hold=1 -> LEN.
//  LEN  : in_ready=1. On the accepted byte N: N==0 or N>DEPTH -> ERR; else latch N -> LOAD.
//  LOAD : in_ready=1. Each accepted byte goes into lane idx (byte 0 -> bits[7:0]), idx++.
//         Accepting byte BPW-1 of a word -> WRITE; idx wraps to 0.
//  WRITE: one cycle; mem_write=1, mem_wdata=packed word, in_ready=0, word_count++.
//         If the new word_count==N -> DONE, else -> LOAD.
//  Latency: last byte of a word accepted in cycle t -> mem_write=1 in cycle t+1.
//   Final word: done=1 and cpu_hold=0 in cycle t+2.
//  DONE : done=1, cpu_hold=0, in_ready=0. Bytes are ignored. start -> CLEAR (reload;
//         cpu_hold returns to 1 the same cycle CLEAR is entered).
//  ERR  : error=1, cpu_hold=1, in_ready=0. start -> CLEAR (error cleared). Only start or rst exits.
//  start while busy is ignored. in_valid without in_ready is not consumed; the source must hold it.
//  No idle gaps are required: back-to-back valid bytes sustain BPW+1 cycles per word.
//  mem_write and mem_clr are never asserted in the same cycle; mem_write never exceeds N pulses.
//  word_count never exceeds N (<= DEPTH); no wrap-around is possible.
// TESTING
//  1 Basic: start; bytes 02,78,56,34,12,EF,BE,AD,DE back-to-back -> one mem_clr pulse;
//    writes 0x12345678 then 0xDEADBEEF; done=1, cpu_hold=0 two cycles after byte DE;
//    word_count=2.
//  2 Bad header: start; byte 00 -> error=1, no mem_write. Repeat with byte 81 (129>DEPTH)
//    -> error=1. Then start; 01,AA,BB,CC,DD -> 0xDDCCBBAA written, done=1, error=0.
//  3 Backpressure/gaps: random in_valid gaps; check in_ready=0 in every WRITE cycle and no
//    byte is lost or duplicated (scoreboard vs. a model).
//  4 Reset mid-load: N=3, assert rst after 6 data bytes -> all outputs at reset values next
//    cycle. A new start with N=1 writes only the fresh word, not stale partial bytes.
//  5 Full depth: N=128 with incrementing words -> exactly 128 mem_write pulses;
//    word_count=128; done=1.
//  6 start ignored in LOAD and WRITE; start in DONE -> reload with mem_clr pulse and cpu_hold
//    re-asserted.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed byte stream and packs it
// little-endian into WIDTH-bit words for an auto-incrementing memory write port.
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_clr,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold
);
    localparam int BPW   = WIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, LEN, LOAD, WRITE, DONE, ERR} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   word_buf, word_nxt;
    logic [CNT_W-1:0]   n_len;
    logic               accept, last_byte;

    assign accept    = in_valid && in_ready;
    assign last_byte = (idx == IDX_W'(BPW - 1));

    // Current word with the incoming byte dropped into its lane
    always_comb begin
        word_nxt = word_buf;
        for (int i = 0; i < BPW; i++)
            if (idx == IDX_W'(i)) word_nxt[i*8 +: 8] = in_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = CLEAR;
            CLEAR:           state_nxt = LEN;
            LEN: if (accept) begin
                if (in_data == 8'd0 || int'(in_data) > DEPTH) state_nxt = ERR;
                else                                            state_nxt = LOAD;
            end
            LOAD:  if (accept && last_byte) state_nxt = WRITE;
            WRITE: state_nxt = (word_count + CNT_W'(1) == n_len) ? DONE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Status/strobe outputs are registered from the next state so they line up with state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            word_buf   <= '0;
            n_len      <= '0;
            in_ready   <= 1'b0;
            mem_clr    <= 1'b0;
            mem_write  <= 1'b0;
            mem_wdata  <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == LEN) || (state_nxt == LOAD);
            mem_clr   <= (state_nxt == CLEAR);
            mem_write <= (state_nxt == WRITE);
            busy      <= (state_nxt == CLEAR) || (state_nxt == LEN) ||
                         (state_nxt == LOAD)  || (state_nxt == WRITE);
            done      <= (state_nxt == DONE);
            error     <= (state_nxt == ERR);
            cpu_hold  <= (state_nxt != DONE);

            case (state)
                CLEAR: begin
                    idx      <= '0;
                    word_buf <= '0;
                end
                LEN: if (accept) n_len <= CNT_W'(in_data);
                LOAD: if (accept) begin
                    word_buf <= word_nxt;
                    idx      <= last_byte ? '0 : idx + 1'b1;
                    if (last_byte) mem_wdata <= word_nxt;
                end
                default: ;
            endcase

            if (state_nxt == CLEAR)  word_count <= '0;
            else if (state == WRITE) word_count <= word_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: drivers push expected words, a negedge monitor pops
// them on every mem_write and checks write-cycle invariants.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_clr, mem_write, busy, done, error, cpu_hold;
    logic [31:0] mem_wdata;
    logic [7:0]  word_count;

    int total = 0, bad = 0;
    int wr_cnt = 0, clr_cnt = 0, pushes = 0;
    logic [31:0] exp_q[$];

    imem_loader #(.WIDTH(32), .DEPTH(128), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_clr(mem_clr), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .word_count(word_count), .busy(busy), .done(done),
        .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every write must match the oldest expected word
    always @(negedge clk) begin
        if (mem_clr) clr_cnt++;
        if (mem_write) begin
            wr_cnt++;
            chk("wr_in_ready_low", in_ready, 0);
            chk("wr_clr_exclusive", mem_clr, 0);
            if (exp_q.size() == 0) chk("unexpected_write", mem_wdata, 64'hDEAD_0000_0000);
            else                   chk("wdata", mem_wdata, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bit ok = 0;
        repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && n < 100) begin
            if (in_ready) begin @(posedge clk); ok = 1; end
            else begin @(negedge clk); n++; end
        end
        if (!ok) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        exp_q.push_back(w);
        pushes++;
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic idle;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_clr"}, mem_clr, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;

        // 1: basic two-word load with latency check
        c0 = clr_cnt;
        pulse_start();
        send_byte(8'h02, 0);
        send_word(32'h12345678, 0);
        send_word(32'hDEADBEEF, 0);
        @(negedge clk); in_valid = 1'b0;
        chk("t1_write_t1", mem_write, 1);
        chk("t1_done_early", done, 0);
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_cpu_hold", cpu_hold, 0);
        chk("t1_word_count", word_count, 2);
        chk("t1_clr_pulses", clr_cnt - c0, 1);

        // 2: malformed headers, then a clean single-word load
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0); idle();
        chk("t2_err_zero", error, 1);
        chk("t2_hold_zero", cpu_hold, 1);
        pulse_start();
        chk("t2_err_cleared", error, 0);
        send_byte(8'h81, 0); idle();
        chk("t2_err_129", error, 1);
        chk("t2_in_ready_err", in_ready, 0);
        chk("t2_no_writes", wr_cnt - w0, 0);
        pulse_start();
        send_byte(8'h01, 0);
        send_word(32'hDDCCBBAA, 0);
        idle();
        wait_done("t2");
        chk("t2_error_off", error, 0);

        // 3: random gaps on the byte stream
        pulse_start();
        send_byte(8'h03, 1);
        send_word(32'h0BADF00D, 1);
        send_word(32'h13579BDF, 1);
        send_word(32'h2468ACE0, 1);
        idle();
        wait_done("t3");
        chk("t3_word_count", word_count, 3);

        // 4: reset mid-load discards the partial word
        pulse_start();
        send_byte(8'h03, 0);
        send_word(32'hA1A2A3A4, 0);
        send_byte(8'hEE, 0);
        send_byte(8'hFF, 0);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("t4");
        chk("t4_queue_drained", exp_q.size(), 0);
        rst = 1'b0;
        pulse_start();
        send_byte(8'h01, 0);
        send_word(32'hCAFEF00D, 0);
        idle();
        wait_done("t4");
        chk("t4_word_count", word_count, 1);

        // 5: full depth
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h80, 0);
        for (int i = 0; i < 128; i++) send_word(32'h1000_0000 + i, 0);
        idle();
        wait_done("t5");
        chk("t5_writes", wr_cnt - w0, 128);
        chk("t5_word_count", word_count, 128);

        // 6: start ignored in LOAD and WRITE; start in DONE reloads
        c0 = clr_cnt;
        pulse_start();
        send_byte(8'h02, 0);
        exp_q.push_back(32'h44332211); pushes++;
        send_byte(8'h11, 0);
        pulse_start();
        chk("t6_load_busy", busy, 1);
        chk("t6_load_no_clr", mem_clr, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        @(negedge clk); in_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t6_write_no_clr", mem_clr, 0);
        chk("t6_write_busy", busy, 1);
        send_word(32'h88776655, 0);
        idle();
        wait_done("t6");
        chk("t6_word_count", word_count, 2);
        chk("t6_clr_once", clr_cnt - c0, 1);
        pulse_start();
        chk("t6_reload_clr", mem_clr, 1);
        chk("t6_reload_hold", cpu_hold, 1);
        chk("t6_reload_done", done, 0);
        send_byte(8'h01, 0);
        send_word(32'h5A5AA5A5, 0);
        idle();
        wait_done("t6r");

        repeat (2) @(negedge clk);
        chk("writes_total", wr_cnt, pushes);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
